// File: rtl/accel_spi_sequencer_pkg.sv
// Shared constants, init table, command packing and FSM state type for the
// accelerometer SPI sequencer.
package accel_spi_pkg;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;
  localparam logic [5:0] REG_FIFO_CTL    = 6'h38;

  localparam logic REG_READ  = 1'b1;
  localparam logic REG_WRITE = 1'b0;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } init_entry_t;

  // POWER_CTL goes last so the part only starts measuring once fully configured
  localparam int INIT_LEN = 4;
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{addr: REG_DATA_FORMAT, data: 8'h00},
    '{addr: REG_INT_ENABLE,  data: 8'h80},
    '{addr: REG_FIFO_CTL,    data: 8'h00},
    '{addr: REG_POWER_CTL,   data: 8'h08}
  };

  typedef enum logic [3:0] {
    ST_STARTUP, ST_ID_SEND, ST_ID_WAIT, ST_CFG_SEND, ST_CFG_WAIT,
    ST_IDLE, ST_RD_SEND, ST_RD_WAIT, ST_EMIT, ST_ERROR
  } seq_state_t;

  function automatic logic [15:0] pack_cmd(input logic rw, input logic [5:0] addr,
                                           input logic [7:0] data);
    return {rw, 1'b0, addr, (rw == REG_READ) ? 8'h00 : data};
  endfunction

endpackage

// File: rtl/accel_spi_sequencer_if.sv
// Command/response streams toward spi_master and the packed sample stream.
interface accel_spi_sequencer_if #(
  parameter int NUM_AXES = 3
);
  logic [15:0]             cmd_tdata;
  logic                    cmd_tvalid;
  logic                    cmd_tready;
  logic [15:0]             rsp_tdata;
  logic                    rsp_tvalid;
  logic                    rsp_tready;
  logic [16*NUM_AXES-1:0]  sample_tdata;
  logic                    sample_tvalid;
  logic                    sample_tready;

  modport master (
    output cmd_tdata, cmd_tvalid, input cmd_tready,
    input rsp_tdata, rsp_tvalid, output rsp_tready,
    output sample_tdata, sample_tvalid, input sample_tready
  );

  modport slave (
    input cmd_tdata, cmd_tvalid, output cmd_tready,
    output rsp_tdata, rsp_tvalid, input rsp_tready,
    input sample_tdata, sample_tvalid, output sample_tready
  );
endinterface

// File: rtl/accel_spi_sequencer_trigger_sync.sv
// INT1 synchroniser and rising-edge detect; ACCEL_POLL_TIMER_EN adds a poll
// timer that re-triggers while the synchronised level stays high.
module accel_trigger_sync #(
  parameter int POLL_PERIOD = 4096
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic data_ready_in,
  input  logic poll_en,
  output logic trig,
  output logic edge_trig
);
  logic [2:0] sync_q;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], data_ready_in};
  end

  assign edge_trig = sync_q[1] & ~sync_q[2];

`ifdef ACCEL_POLL_TIMER_EN
  localparam int PW = $clog2(POLL_PERIOD + 1);
  logic [PW-1:0] poll_cnt;
  logic          poll_hit;

  assign poll_hit = poll_en & sync_q[1] & ~edge_trig & (poll_cnt == '0);

  // reloads on every real edge so a poll never lands right after one
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)
      poll_cnt <= PW'(POLL_PERIOD - 1);
    else if (!poll_en || !sync_q[1] || edge_trig || poll_hit)
      poll_cnt <= PW'(POLL_PERIOD - 1);
    else
      poll_cnt <= poll_cnt - PW'(1);
  end

  assign trig = edge_trig | poll_hit;
`else
  logic unused_poll;
  assign unused_poll = poll_en & (POLL_PERIOD > 0);
  assign trig        = edge_trig;
`endif

endmodule

// File: rtl/accel_spi_sequencer.sv
// Accelerometer bring-up and sample-read sequencer over a shared spi_master.
// Optional poll timer: ACCEL_POLL_TIMER_EN.
//   STARTUP  power-up wait      | ID_SEND/WAIT  read and check DEVID
//   CFG_SEND/WAIT  replay init  | IDLE          wait for trigger
//   RD_SEND/WAIT   read bytes   | EMIT          present sample
//   ERROR    DEVID failed, terminal until reset
module accel_spi_sequencer
  import accel_spi_pkg::*;
#(
  parameter int         NUM_AXES       = 3,
  parameter logic [7:0] EXPECTED_DEVID = 8'hE5,
  parameter logic [5:0] DATA_BASE_ADDR = REG_DATAX0,
  parameter int         STARTUP_CYCLES = 1024,
  parameter int         ID_RETRIES     = 3,
  parameter int         POLL_PERIOD    = 4096
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic                        data_ready_in,
  accel_spi_sequencer_if.master       bus,
  output logic                        init_done,
  output logic                        id_error,
  output logic [7:0]                  overrun_count
);
  localparam int NBYTES = 2 * NUM_AXES;
  localparam int BW     = $clog2(NBYTES);
  localparam int SW     = $clog2(STARTUP_CYCLES + 1);
  localparam int RW     = $clog2(ID_RETRIES + 1);
  localparam int CW     = $clog2(INIT_LEN);

  seq_state_t          state, state_nx;
  logic [SW-1:0]       start_cnt;
  logic [RW-1:0]       retry_cnt;
  logic [CW-1:0]       cfg_idx;
  logic [BW-1:0]       byte_idx;
  logic [8*NBYTES-1:0] byte_buf;
  logic                trig, edge_trig, accept, rsp_fire, rdy_q;
  logic                id_match, cfg_last, byte_last;
  logic                unused_rsp_hi;

  accel_trigger_sync #(.POLL_PERIOD(POLL_PERIOD)) u_trig_sync (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .data_ready_in (data_ready_in),
    .poll_en       (init_done),
    .trig          (trig),
    .edge_trig     (edge_trig)
  );

  assign bus.rsp_tready = rdy_q;
  assign rsp_fire       = bus.rsp_tvalid & rdy_q;
  assign id_match       = (bus.rsp_tdata[7:0] == EXPECTED_DEVID);
  assign cfg_last       = (cfg_idx == CW'(INIT_LEN - 1));
  assign byte_last      = (byte_idx == BW'(NBYTES - 1));
  assign accept         = trig && (state == ST_IDLE) && (!bus.sample_tvalid || bus.sample_tready);
  assign unused_rsp_hi  = ^bus.rsp_tdata[15:8];

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state <= ST_STARTUP;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = '0;
    unique case (state)
      ST_STARTUP: if (start_cnt == '0) state_nx = ST_ID_SEND;
      ST_ID_SEND: begin
        bus.cmd_tvalid = 1'b1;
        bus.cmd_tdata  = pack_cmd(REG_READ, REG_DEVID, 8'h00);
        if (bus.cmd_tready) state_nx = ST_ID_WAIT;
      end
      ST_ID_WAIT: if (rsp_fire) begin
        if (id_match)                            state_nx = ST_CFG_SEND;
        else if (int'(retry_cnt) + 1 < ID_RETRIES) state_nx = ST_ID_SEND;
        else                                     state_nx = ST_ERROR;
      end
      ST_CFG_SEND: begin
        bus.cmd_tvalid = 1'b1;
        bus.cmd_tdata  = pack_cmd(REG_WRITE, INIT_TABLE[cfg_idx].addr, INIT_TABLE[cfg_idx].data);
        if (bus.cmd_tready) state_nx = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: if (rsp_fire) state_nx = cfg_last ? ST_IDLE : ST_CFG_SEND;
      ST_IDLE:     if (accept) state_nx = ST_RD_SEND;
      ST_RD_SEND: begin
        bus.cmd_tvalid = 1'b1;
        bus.cmd_tdata  = pack_cmd(REG_READ, DATA_BASE_ADDR + 6'(byte_idx), 8'h00);
        if (bus.cmd_tready) state_nx = ST_RD_WAIT;
      end
      ST_RD_WAIT:  if (rsp_fire) state_nx = byte_last ? ST_EMIT : ST_RD_SEND;
      ST_EMIT:     state_nx = ST_IDLE;
      ST_ERROR:    state_nx = ST_ERROR;
      default:     state_nx = ST_STARTUP;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rdy_q             <= 1'b0;
      start_cnt         <= SW'(STARTUP_CYCLES - 1);
      retry_cnt         <= '0;
      cfg_idx           <= '0;
      byte_idx          <= '0;
      byte_buf          <= '0;
      bus.sample_tdata  <= '0;
      bus.sample_tvalid <= 1'b0;
      init_done         <= 1'b0;
      id_error          <= 1'b0;
      overrun_count     <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (state == ST_STARTUP && start_cnt != '0) start_cnt <= start_cnt - SW'(1);
      if (state == ST_ID_WAIT && rsp_fire && !id_match) retry_cnt <= retry_cnt + RW'(1);
      if (state_nx == ST_ERROR) id_error <= 1'b1;
      if (state == ST_CFG_WAIT && rsp_fire) cfg_idx <= cfg_idx + CW'(1);
      if (state == ST_CFG_WAIT && state_nx == ST_IDLE) init_done <= 1'b1;
      if (accept) byte_idx <= '0;
      if (state == ST_RD_WAIT && rsp_fire) begin
        byte_buf[{byte_idx, 3'b000} +: 8] <= bus.rsp_tdata[7:0];
        byte_idx <= byte_idx + BW'(1);
      end
      if (state == ST_EMIT) begin
        bus.sample_tdata  <= byte_buf;
        bus.sample_tvalid <= 1'b1;
      end else if (bus.sample_tvalid && bus.sample_tready) begin
        bus.sample_tvalid <= 1'b0;
      end
      // only real edges count as overruns; a busy poll tick is simply retried later
      if (edge_trig && !accept && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer with a behavioural spi_master model.
module tb_accel_spi_sequencer;
  localparam int NUM_AXES = 3;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_ready_in = 1'b0;
  logic       init_done, id_error;
  logic [7:0] overrun_count;

  accel_spi_sequencer_if #(.NUM_AXES(NUM_AXES)) bus();

  accel_spi_sequencer #(.NUM_AXES(NUM_AXES)) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .data_ready_in (data_ready_in),
    .bus           (bus),
    .init_done     (init_done),
    .id_error      (id_error),
    .overrun_count (overrun_count)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // spi_master model: registers and logs every accepted command
  logic [7:0]  devid_val = 8'hE5;
  logic [7:0]  mem [6];
  logic [15:0] cmd_log [$];
  logic [47:0] sample_q [$];
  logic [15:0] mc;
  int          rsp_count = 0;

  function automatic logic [15:0] rsp_for(input logic [15:0] c);
    int a;
    a = int'(c[13:8]);
    if (!c[15]) return 16'h0000;
    if (a == 0) return {8'h00, devid_val};
    if (a >= 'h32 && a <= 'h37) return {8'hA5, mem[a - 'h32]};
    return 16'h0000;
  endfunction

  initial begin
    bus.rsp_tvalid = 1'b0;
    bus.rsp_tdata  = 16'h0;
    forever begin
      @(negedge sys_clk);
      if (reset && bus.cmd_tvalid && bus.cmd_tready) begin
        mc = bus.cmd_tdata;
        cmd_log.push_back(mc);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        bus.rsp_tdata  = rsp_for(mc);
        bus.rsp_tvalid = 1'b1;
        rsp_count++;
        @(posedge sys_clk);
        #1;
        bus.rsp_tvalid = 1'b0;
      end
    end
  end

  always @(negedge sys_clk)
    if (reset && bus.sample_tvalid && bus.sample_tready) sample_q.push_back(bus.sample_tdata);

  typedef struct {
    logic [7:0]  b [6];
    logic [47:0] exp;
  } vec_t;
  vec_t vecs [4];

  logic [15:0] init_exp [5] = '{16'h8000, 16'h3100, 16'h2E80, 16'h3800, 16'h2D08};
  logic [15:0] rd_exp   [6] = '{16'hB200, 16'hB300, 16'hB400, 16'hB500, 16'hB600, 16'hB700};

  task automatic set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input logic [7:0] b5, input logic [47:0] e);
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
    vecs[i].b[3] = b3; vecs[i].b[4] = b4; vecs[i].b[5] = b5;
    vecs[i].exp  = e;
  endtask

  task automatic load_mem(input int i);
    for (int k = 0; k < 6; k++) mem[k] = vecs[i].b[k];
  endtask

  task automatic pulse_drdy();
    @(posedge sys_clk); #1 data_ready_in = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 data_ready_in = 1'b0;
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic wait_samples(input string name, input int n, input int budget);
    int c = 0;
    while (sample_q.size() < n && c < budget) begin
      @(posedge sys_clk); #1; c++;
    end
    check(name, sample_q.size(), n);
  endtask

  task automatic wait_init(input string name);
    int c = 0;
    while (!init_done && c < 2000) begin
      @(posedge sys_clk); #1; c++;
    end
    check({name, "_done"}, init_done, 1);
    check({name, "_rsp_count"}, rsp_count, 5);
    check({name, "_cmd_count"}, cmd_log.size(), 5);
    for (int k = 0; k < 5 && k < cmd_log.size(); k++) check({name, "_cmd"}, cmd_log[k], init_exp[k]);
  endtask

  task automatic release_reset();
    cmd_log.delete();
    rsp_count = 0;
    @(negedge sys_clk);
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int n, n0, unstable, seen, extra_valid;

  initial begin
    set_vec(0, 8'h10, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h01, 48'h0100_FFF0_0010);
    set_vec(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 48'h0000_0000_0000);
    set_vec(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 48'hFFFF_FFFF_FFFF);
    set_vec(3, 8'h01, 8'h80, 8'h7F, 8'h00, 8'h34, 8'h12, 48'h1234_007F_8001);
    bus.cmd_tready    = 1'b1;
    bus.sample_tready = 1'b1;
    load_mem(0);

    #2 reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cmd_tvalid", bus.cmd_tvalid, 0);
    check("rst_sample_tvalid", bus.sample_tvalid, 0);
    check("rst_rsp_tready", bus.rsp_tready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_id_error", id_error, 0);
    check("rst_overrun", overrun_count, 0);

    release_reset();
    n = 0;
    while (!bus.cmd_tvalid && n < 2000) begin
      @(posedge sys_clk); #1; n++;
    end
    check("startup_cycles", n, 1024);
    check("first_cmd", bus.cmd_tdata, 16'h8000);
    check("rsp_tready_up", bus.rsp_tready, 1);
    wait_init("init");

    for (int i = 0; i < 4; i++) begin
      load_mem(i);
      cmd_log.delete();
      n0 = sample_q.size();
      pulse_drdy();
      wait_samples("vec_wait", n0 + 1, 300);
      repeat (20) @(posedge sys_clk);
      check("vec_beats", sample_q.size(), n0 + 1);
      if (sample_q.size() > n0) check("vec_data", sample_q[n0], vecs[i].exp);
      check("vec_reads", cmd_log.size(), 6);
      for (int k = 0; k < 6 && k < cmd_log.size(); k++) check("vec_read_cmd", cmd_log[k], rd_exp[k]);
    end
    check("no_overrun", overrun_count, 0);

    // downstream stall: further edges are dropped and counted
    bus.sample_tready = 1'b0;
    load_mem(3);
    n0 = sample_q.size();
    pulse_drdy();
    n = 0;
    while (!bus.sample_tvalid && n < 300) begin
      @(posedge sys_clk); #1; n++;
    end
    check("held_valid", bus.sample_tvalid, 1);
    check("held_data", bus.sample_tdata, vecs[3].exp);
    cmd_log.delete();
    load_mem(0);
    pulse_drdy();
    pulse_drdy();
    repeat (30) @(posedge sys_clk);
    check("ovr_no_reads", cmd_log.size(), 0);
    check("ovr_count", overrun_count, 2);
    check("ovr_data_stable", bus.sample_tdata, vecs[3].exp);
    check("ovr_valid_stable", bus.sample_tvalid, 1);
    @(posedge sys_clk); #1 bus.sample_tready = 1'b1;
    wait_samples("ovr_drain", n0 + 1, 20);
    if (sample_q.size() > n0) check("ovr_drain_data", sample_q[n0], vecs[3].exp);

    // command back-pressure in the middle of a read burst
    load_mem(0);
    cmd_log.delete();
    n0 = sample_q.size();
    @(posedge sys_clk); #1 data_ready_in = 1'b1;
    n = 0;
    while (cmd_log.size() < 2 && n < 300) begin
      @(posedge sys_clk); #1; n++;
    end
    bus.cmd_tready = 1'b0;
    data_ready_in  = 1'b0;
    unstable = 0;
    seen = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (bus.cmd_tvalid) begin
        seen++;
        if (bus.cmd_tdata !== 16'hB400) unstable++;
      end
    end
    check("stall_unstable", unstable, 0);
    check("stall_valid_held", seen >= 15, 1);
    check("stall_no_issue", cmd_log.size(), 2);
    @(posedge sys_clk); #1 bus.cmd_tready = 1'b1;
    wait_samples("stall_wait", n0 + 1, 300);
    repeat (10) @(posedge sys_clk);
    check("stall_reads", cmd_log.size(), 6);
    if (sample_q.size() > n0) check("stall_data", sample_q[n0], vecs[0].exp);

    // reset while a data read response is outstanding
    load_mem(3);
    cmd_log.delete();
    @(posedge sys_clk); #1 data_ready_in = 1'b1;
    n = 0;
    while (cmd_log.size() < 1 && n < 300) begin
      @(posedge sys_clk); #1; n++;
    end
    reset = 1'b0;
    data_ready_in = 1'b0;
    #1;
    check("midrst_cmd_tvalid", bus.cmd_tvalid, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_rsp_tready", bus.rsp_tready, 0);
    check("midrst_overrun", overrun_count, 0);
    repeat (5) @(posedge sys_clk);
    release_reset();
    wait_init("reinit");
    load_mem(0);
    n0 = sample_q.size();
    pulse_drdy();
    wait_samples("reinit_wait", n0 + 1, 300);
    if (sample_q.size() > n0) check("reinit_data", sample_q[n0], vecs[0].exp);

`ifdef ACCEL_POLL_TIMER_EN
    // level held high with no new edge: poll timer re-reads
    n0 = sample_q.size();
    @(posedge sys_clk); #1 data_ready_in = 1'b1;
    wait_samples("poll_first", n0 + 1, 300);
    wait_samples("poll_second", n0 + 2, 4400);
    #1 data_ready_in = 1'b0;
    check("poll_overrun", overrun_count, 0);
`endif

    // DEVID never matches: three attempts then sticky error
    devid_val = 8'h00;
    @(posedge sys_clk); #1 reset = 1'b0;
    repeat (3) @(posedge sys_clk);
    release_reset();
    n = 0;
    while (!id_error && n < 3000) begin
      @(posedge sys_clk); #1; n++;
    end
    check("id_error_set", id_error, 1);
    extra_valid = 0;
    repeat (200) begin
      @(negedge sys_clk);
      if (bus.cmd_tvalid) extra_valid++;
    end
    check("id_no_more_cmds", extra_valid, 0);
    check("id_cmd_count", cmd_log.size(), 3);
    for (int k = 0; k < 3 && k < cmd_log.size(); k++) check("id_cmd", cmd_log[k], 16'h8000);
    check("id_error_sticky", id_error, 1);
    check("id_no_init", init_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_spi_sequencer.md
Name: accel_spi_sequencer

Overview:
- Parametrised SPI register sequencer for ADXL345-class accelerometers; successor to the single-device fixed driver.
- Sits between the accelerometer interrupt pin and the shared spi_master command/response streams (16-bit transfers, SPI mode 3).
- After power-up it waits, reads and checks DEVID with retries, then replays a configuration write table.
- On each data-ready trigger it reads NUM_AXES x 2 data bytes and emits one packed sample beat.

Parameters:
- NUM_AXES, 3, axes sampled (1..3); sample beat width = 16*NUM_AXES.
- EXPECTED_DEVID, 8'hE5, required DEVID value.
- DATA_BASE_ADDR, 6'h32, address of DATAX0; axis k low byte at base+2k, high byte at base+2k+1.
- STARTUP_CYCLES, 1024, sys_clk cycles waited after reset before the first command.
- ID_RETRIES, 3, DEVID attempts before a sticky error.
- POLL_PERIOD, 4096, timer period in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- data_ready_in  in  1  raw INT1 pin, asynchronous.
- cmd_tdata  out  16  command word to spi_master: [15]=R/W (1=read), [14]=MB (always 0), [13:8]=addr, [7:0]=write data (0 for reads).
- cmd_tvalid  out  1  command valid.
- cmd_tready  in  1  spi_master accepts command.
- rsp_tdata  in  16  response word; [7:0] is the register value.
- rsp_tvalid  in  1  response valid.
- rsp_tready  out  1  always 1 out of reset.
- sample_tdata  out  16*NUM_AXES  axis k at [16k+:16], {high,low}, two's complement.
- sample_tvalid  out  1  sample valid.
- sample_tready  in  1  downstream ready.
- init_done  out  1  high while in IDLE/read loop.
- id_error  out  1  sticky until reset.
- overrun_count  out  8  saturating count of dropped triggers.

Behaviour:
- Reset values: all outputs 0 except rsp_tready (1 when reset deasserted); state STARTUP; counters 0.
- Transfer discipline: one command outstanding at a time. cmd_tvalid holds with stable data until cmd_tready. The block then waits for exactly one rsp beat. Responses arriving outside WAIT states are discarded.
- STARTUP: count STARTUP_CYCLES, then go to ID_SEND.
- ID_SEND: issue 16'h8000; go to ID_WAIT.
- ID_WAIT: on rsp, compare [7:0] with EXPECTED_DEVID.
  - Match: go to CFG_SEND, idx=0.
  - Mismatch: retry count++; if below ID_RETRIES, return to ID_SEND; otherwise set id_error and go to ERROR. ERROR is terminal until reset; no further commands.
- CFG_SEND/CFG_WAIT: send table entry idx, wait for its rsp, idx++. After the last entry, set init_done and go to IDLE.
  - Table order: DATA_FORMAT 0x31<=0x00 (4-wire, right-justified, +-2 g); INT_ENABLE 0x2E<=0x80; FIFO_CTL 0x38<=0x00 (bypass); POWER_CTL 0x2D<=0x08.
- data_ready_in path: 2-flop synchroniser, then rising-edge detect. Trigger = edge.
- IDLE: on trigger with sample_tvalid low, go to RD_SEND with byte index b=0.
- RD_SEND/RD_WAIT: read address DATA_BASE_ADDR+b; store rsp[7:0] in byte slot b. Repeat for b = 0 .. 2*NUM_AXES-1.
- EMIT: load sample_tdata, assert sample_tvalid, return to IDLE. sample_tvalid clears on the tready handshake. sample_tdata is stable while valid.
- Overrun: a trigger arriving outside IDLE, or while sample_tvalid && !sample_tready, is dropped and overrun_count++ (saturates at 255). A trigger in the same cycle as the output handshake is accepted.
- Latency, trigger to sample_tvalid: 2 sync + 1 edge + sum of the per-byte SPI round trips + 1 cycle.
- Reset mid-operation: asynchronous return to STARTUP, full re-init; any partial sample is discarded.

Optional Feature:
- Macro: ACCEL_POLL_TIMER_EN.
- Defined: a free-running counter raises a synthetic trigger every POLL_PERIOD cycles while init_done is high and the synchronised data_ready level is high. This recovers from a missed edge.
  - The timer restarts on every real trigger.
  - A timer trigger dropped for being busy does not increment overrun_count.
- Undefined: no counter; triggers come from edges only.

Decomposition:
- Package accel_spi_pkg holds:
  - register address constants (DEVID, POWER_CTL, DATA_FORMAT, INT_ENABLE, FIFO_CTL, DATAX0);
  - REG_READ/REG_WRITE bits;
  - command-word pack function;
  - init table as a constant array plus its length;
  - the state enum.
- One sub-module, accel_trigger_sync: synchroniser, edge detect and optional poll timer.

Test Plan:
- Reset release, SPI model returns DEVID 0xE5 -> after 1024 cycles, command words in order 8000, 3100, 2E80, 3800, 2D08; init_done=1 after the fifth rsp.
- DEVID model returns 0x00 three times -> exactly three 8000 commands, id_error=1, no further cmd_tvalid.
- Data-ready edge, model bytes 32..37 = 10,00,F0,FF,00,01 -> exactly one sample beat, tdata=48'h0100_FFF0_0010.
- sample_tready held low, then two more edges -> no SPI reads issued, overrun_count=2; first sample unchanged until tready.
- cmd_tready low for 20 cycles mid-read -> cmd_tdata stable, no duplicate command, correct sample afterwards.
- Reset asserted during RD_WAIT -> outputs return to 0 immediately; full init sequence replays. With ACCEL_POLL_TIMER_EN, data_ready held high with no edge -> a read every 4096 cycles.
